lb_event_hub: RTL and testbench

- Parametrised local-bus front end for the capture core.
- Contains a host register block (ID, scratch, user_ctrl, status) and per-channel synchronised rising-edge counters over NUM_CH event inputs.
- Forwards a decoded address region to a downstream slave (e.g. sump2 ctrl/data), with read-timeout protection.
- Sits between the bus bridge and the sump2 instance; one clock domain, clk_lb.

---
 rtl/lb_event_hub_if.sv | 12 +
 rtl/lb_event_hub.sv | 197 +++++++++++++++++++
 tb/tb_lb_event_hub.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_event_hub_if.sv
// rtl/lb_event_hub_if.sv - local-bus strobe/address/data bundle shared by host and downstream sides
interface lb_event_hub_if;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wr_d;
    logic [31:0] rd_d;
    logic        rd_rdy;

    modport master (output wr, rd, addr, wr_d, input rd_d, rd_rdy);
    modport slave  (input wr, rd, addr, wr_d, output rd_d, rd_rdy);
endinterface

// File: rtl/lb_event_hub.sv
// rtl/lb_event_hub.sv - local-bus register block, event edge counters and forwarded-read proxy
module lb_event_hub #(
    parameter int          NUM_CH      = 16,
    parameter int          CNT_BITS    = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h53554D50,
    parameter logic [3:0]  SLV_REGION  = 4'h1,
    parameter int          TIMEOUT     = 15
) (
    input  logic                clk_lb,
    input  logic                reset_n,
    lb_event_hub_if.slave       lb,
    lb_event_hub_if.master      slv,
    input  logic [NUM_CH-1:0]   events_din,
    output logic [NUM_CH-1:0]   events_sync,
    output logic [31:0]         user_ctrl
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t              state_q;
    logic [7:0]          timer_q;
    logic [31:0]         scratch_q;
    logic [31:0]         user_ctrl_q;
    logic                freeze_q;
    logic                timeout_q;
    logic                overrun_q;
    logic [31:0]         rd_d_q;
    logic                rd_rdy_q;
    logic                slv_wr_q;
    logic                slv_rd_q;
    logic [31:0]         slv_addr_q;
    logic [31:0]         slv_wr_d_q;
    logic                clr_q;
    logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]   last_q;
    logic [CNT_BITS-1:0] cnt_q [NUM_CH];

    logic [3:0]          region;
    logic [15:0]         off;
    logic                is_local;
    logic                is_fwd;
    logic                rd_ok;
    logic                fwd_rd;
    logic                plain_rd;
    logic                wr_local;
    logic                fwd_wr;
    logic                timeout_evt;
    logic                overrun_evt;
    logic                status_w1c;
    logic [4:0]          cnt_idx;
    logic [31:0]         local_rdata;
    logic [NUM_CH-1:0]   evt_rise;

    assign region      = lb.addr[19:16];
    assign off         = lb.addr[15:0];
    assign is_local    = (region == 4'h0);
    assign is_fwd      = (region == SLV_REGION) && !is_local;
    // Only one read may be in flight; any read arriving while the proxy is busy is dropped.
    assign rd_ok       = lb.rd && (state_q == ST_IDLE);
    assign fwd_rd      = rd_ok && is_fwd;
    assign plain_rd    = rd_ok && !is_fwd;
    assign wr_local    = lb.wr && is_local;
    assign fwd_wr      = lb.wr && is_fwd;
    assign timeout_evt = (state_q == ST_WAIT) && !slv.rd_rdy && (timer_q == 8'd0);
    assign overrun_evt = lb.rd && (state_q != ST_IDLE);
    assign status_w1c  = wr_local && (off == 16'h000C);
    assign cnt_idx     = off[6:2];
    assign evt_rise    = sync_q[SYNC_STAGES-1] & ~last_q;

    always_comb begin
        local_rdata = '0;
        if (is_local) begin
            case (off)
                16'h0000: local_rdata = ID_VALUE;
                16'h0004: local_rdata = scratch_q;
                16'h0008: local_rdata = user_ctrl_q;
                16'h000C: local_rdata = {18'b0, 6'(NUM_CH), 6'b0, overrun_q, timeout_q};
                16'h0010: local_rdata = {30'b0, freeze_q, 1'b0};
                default: begin
                    if ((off[15:7] == 9'h002) && (off[1:0] == 2'b00)) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cnt_idx == 5'(i)) local_rdata = 32'(cnt_q[i]);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            scratch_q   <= '0;
            user_ctrl_q <= '0;
            freeze_q    <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rd_d_q      <= '0;
            rd_rdy_q    <= 1'b0;
            slv_wr_q    <= 1'b0;
            slv_rd_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wr_d_q  <= '0;
        end else begin
            rd_rdy_q <= 1'b0;
            slv_wr_q <= 1'b0;
            slv_rd_q <= 1'b0;

            if (wr_local) begin
                case (off)
                    16'h0004: scratch_q   <= lb.wr_d;
                    16'h0008: user_ctrl_q <= lb.wr_d;
                    16'h0010: freeze_q    <= lb.wr_d[1];
                    default: ;
                endcase
            end

            // A new sticky event outranks a simultaneous write-1-to-clear.
            timeout_q <= timeout_evt | (timeout_q & ~(status_w1c & lb.wr_d[0]));
            overrun_q <= overrun_evt | (overrun_q & ~(status_w1c & lb.wr_d[1]));

            if (fwd_wr) begin
                slv_wr_q   <= 1'b1;
                slv_addr_q <= lb.addr;
                slv_wr_d_q <= lb.wr_d;
            end

            if (plain_rd) begin
                rd_rdy_q <= 1'b1;
                rd_d_q   <= local_rdata;
            end

            case (state_q)
                ST_IDLE: begin
                    if (fwd_rd) begin
                        state_q    <= ST_ISSUE;
                        slv_rd_q   <= 1'b1;
                        slv_addr_q <= lb.addr;
                        timer_q    <= 8'(TIMEOUT);
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    timer_q <= timer_q - 8'd1;
                end
                ST_WAIT: begin
                    if (slv.rd_rdy) begin
                        state_q  <= ST_IDLE;
                        rd_d_q   <= slv.rd_d;
                        rd_rdy_q <= 1'b1;
                    end else if (timer_q == 8'd0) begin
                        state_q  <= ST_IDLE;
                        rd_d_q   <= 32'hDEADDEAD;
                        rd_rdy_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            last_q <= '0;
            clr_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            sync_q[0] <= events_din;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            last_q <= sync_q[SYNC_STAGES-1];
            clr_q  <= wr_local && (off == 16'h0010) && lb.wr_d[0];
            // Clear lands one cycle after the write and swallows any edge seen in that cycle.
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_q) begin
                    cnt_q[i] <= '0;
                end else if (evt_rise[i] && !freeze_q && (cnt_q[i] != {CNT_BITS{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
    end

    assign lb.rd_d     = rd_d_q;
    assign lb.rd_rdy   = rd_rdy_q;
    assign slv.wr      = slv_wr_q;
    assign slv.rd      = slv_rd_q;
    assign slv.addr    = slv_addr_q;
    assign slv.wr_d    = slv_wr_d_q;
    assign events_sync = sync_q[SYNC_STAGES-1];
    assign user_ctrl   = user_ctrl_q;

endmodule

// File: tb/tb_lb_event_hub.sv
// tb/tb_lb_event_hub.sv - directed bench for lb_event_hub (default instance plus a 4-bit-counter instance)
module tb_lb_event_hub;

    logic        clk_lb;
    logic        reset_n;
    logic [15:0] events0;
    logic [15:0] sync0;
    logic [31:0] uctrl0;
    logic [1:0]  events1;
    logic [1:0]  sync1;
    logic [31:0] uctrl1;

    int n_err;
    int n_chk;
    int slv_rd_pulses;
    int base_pulses;
    int cyc;
    logic seen;

    lb_event_hub_if h0 ();
    lb_event_hub_if s0 ();
    lb_event_hub_if h1 ();
    lb_event_hub_if s1 ();

    lb_event_hub dut0 (
        .clk_lb      (clk_lb),
        .reset_n     (reset_n),
        .lb          (h0),
        .slv         (s0),
        .events_din  (events0),
        .events_sync (sync0),
        .user_ctrl   (uctrl0)
    );

    lb_event_hub #(.NUM_CH(2), .CNT_BITS(4)) dut1 (
        .clk_lb      (clk_lb),
        .reset_n     (reset_n),
        .lb          (h1),
        .slv         (s1),
        .events_din  (events1),
        .events_sync (sync1),
        .user_ctrl   (uctrl1)
    );

    initial clk_lb = 1'b0;
    always #5 clk_lb = ~clk_lb;

    always @(posedge clk_lb) if (s0.rd === 1'b1) slv_rd_pulses = slv_rd_pulses + 1;

    task automatic tick();
        @(posedge clk_lb);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd0(input logic [31:0] a, input logic [31:0] exp, input string tag);
        h0.addr = a;
        h0.rd   = 1'b1;
        tick();
        h0.rd   = 1'b0;
        chk({tag, "_rdy"}, 32'(h0.rd_rdy), 32'd1);
        chk(tag, h0.rd_d, exp);
        tick();
        chk({tag, "_rdy_end"}, 32'(h0.rd_rdy), 32'd0);
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d);
        h0.addr = a;
        h0.wr_d = d;
        h0.wr   = 1'b1;
        tick();
        h0.wr   = 1'b0;
    endtask

    task automatic pulse0(input int ch);
        events0[ch] = 1'b1;
        tick(); tick();
        events0[ch] = 1'b0;
        tick(); tick();
    endtask

    initial begin
        n_err = 0; n_chk = 0; slv_rd_pulses = 0;
        reset_n = 1'b0;
        events0 = '0; events1 = '0;
        h0.wr = 0; h0.rd = 0; h0.addr = '0; h0.wr_d = '0;
        h1.wr = 0; h1.rd = 0; h1.addr = '0; h1.wr_d = '0;
        s0.rd_d = '0; s0.rd_rdy = 0;
        s1.rd_d = '0; s1.rd_rdy = 0;
        tick(); tick();
        chk("rst_rdy", 32'(h0.rd_rdy), 32'd0);
        chk("rst_uctrl", uctrl0, 32'd0);
        chk("rst_slv_addr", s0.addr, 32'd0);
        reset_n = 1'b1;
        tick();

        rd0(32'h0000_0000, 32'h53554D50, "id");
        rd0(32'h0000_000C, 32'h0000_1000, "status_rst");
        rd0(32'h0000_0008, 32'h0000_0000, "uctrl_rst");

        wr0(32'h0000_0004, 32'hA5A5_0001);
        wr0(32'h0000_0008, 32'hA5A5_0001);
        chk("uctrl_port", uctrl0, 32'hA5A5_0001);
        rd0(32'h0000_0004, 32'hA5A5_0001, "scratch");
        rd0(32'h0000_0008, 32'hA5A5_0001, "uctrl_rb");
        rd0(32'h0000_0030, 32'h0000_0000, "hole");
        rd0(32'h0005_0000, 32'h0000_0000, "unmapped");

        // forwarded write
        wr0(32'h0001_0008, 32'hCAFE_F00D);
        chk("fwr_pulse", 32'(s0.wr), 32'd1);
        chk("fwr_addr", s0.addr, 32'h0001_0008);
        chk("fwr_data", s0.wr_d, 32'hCAFE_F00D);
        tick();
        chk("fwr_pulse_end", 32'(s0.wr), 32'd0);

        // forwarded read answered 3 cycles after slv_rd
        base_pulses = slv_rd_pulses;
        h0.addr = 32'h0001_0004; h0.rd = 1'b1;
        tick();
        h0.rd = 1'b0;
        chk("frd_slv_rd", 32'(s0.rd), 32'd1);
        chk("frd_slv_addr", s0.addr, 32'h0001_0004);
        tick();
        chk("frd_slv_rd_end", 32'(s0.rd), 32'd0);
        tick();
        chk("frd_no_early_rdy", 32'(h0.rd_rdy), 32'd0);
        s0.rd_d = 32'h1234_5678; s0.rd_rdy = 1'b1;
        tick();
        s0.rd_rdy = 1'b0;
        chk("frd_rdy", 32'(h0.rd_rdy), 32'd1);
        chk("frd_data", h0.rd_d, 32'h1234_5678);
        tick();
        chk("frd_rdy_end", 32'(h0.rd_rdy), 32'd0);
        chk("frd_one_slv_rd", 32'(slv_rd_pulses - base_pulses), 32'd1);

        // forwarded read with no answer: rdy after 2 + TIMEOUT edges
        h0.addr = 32'h0001_0010; h0.rd = 1'b1;
        seen = 1'b0; cyc = 0;
        tick();
        h0.rd = 1'b0;
        cyc = 1;
        while (!seen && cyc < 40) begin
            if (h0.rd_rdy === 1'b1) seen = 1'b1;
            else begin tick(); cyc++; end
        end
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_latency", 32'(cyc), 32'd17);
        chk("to_data", h0.rd_d, 32'hDEADDEAD);
        tick();
        rd0(32'h0000_000C, 32'h0000_1001, "status_to");
        wr0(32'h0000_000C, 32'h0000_0001);
        rd0(32'h0000_000C, 32'h0000_1000, "status_to_clr");

        // second read while one is outstanding is dropped
        base_pulses = slv_rd_pulses;
        h0.addr = 32'h0001_0000; h0.rd = 1'b1;
        tick();
        h0.rd = 1'b0;
        tick();
        h0.addr = 32'h0000_0000; h0.rd = 1'b1;
        tick();
        h0.rd = 1'b0;
        chk("ovr_no_rdy", 32'(h0.rd_rdy), 32'd0);
        tick();
        chk("ovr_no_rdy2", 32'(h0.rd_rdy), 32'd0);
        s0.rd_d = 32'h0BAD_F00D; s0.rd_rdy = 1'b1;
        tick();
        s0.rd_rdy = 1'b0;
        chk("ovr_rdy", 32'(h0.rd_rdy), 32'd1);
        chk("ovr_data", h0.rd_d, 32'h0BAD_F00D);
        chk("ovr_one_slv_rd", 32'(slv_rd_pulses - base_pulses), 32'd1);
        tick();
        rd0(32'h0000_000C, 32'h0000_1002, "status_ovr");

        // event sync depth and counting on channel 3
        events0[3] = 1'b1;
        tick();
        chk("sync_stage1", 32'(sync0[3]), 32'd0);
        tick();
        chk("sync_stage2", 32'(sync0[3]), 32'd1);
        events0[3] = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) pulse0(3);
        tick(); tick(); tick();
        rd0(32'h0000_010C, 32'd5, "cnt3");
        rd0(32'h0000_0100, 32'd0, "cnt0");
        wr0(32'h0000_0010, 32'h0000_0002);
        rd0(32'h0000_0010, 32'h0000_0002, "freeze_rb");
        pulse0(3); pulse0(3);
        tick(); tick(); tick();
        rd0(32'h0000_010C, 32'd5, "cnt3_frozen");
        wr0(32'h0000_0010, 32'h0000_0001);
        tick();
        rd0(32'h0000_010C, 32'd0, "cnt3_cleared");
        rd0(32'h0000_0010, 32'h0000_0000, "ctrl_after_clr");

        // 4-bit counters saturate at 15
        for (int i = 0; i < 20; i++) begin
            events1[0] = 1'b1;
            tick(); tick();
            events1[0] = 1'b0;
            tick(); tick();
        end
        tick(); tick(); tick();
        h1.addr = 32'h0000_0100; h1.rd = 1'b1;
        tick();
        h1.rd = 1'b0;
        chk("sat_rdy", 32'(h1.rd_rdy), 32'd1);
        chk("sat_cnt", h1.rd_d, 32'd15);
        tick();
        h1.addr = 32'h0000_0108; h1.rd = 1'b1;
        tick();
        h1.rd = 1'b0;
        chk("absent_ch", h1.rd_d, 32'd0);
        tick();

        // reset while waiting on the slave
        h0.addr = 32'h0001_0020; h0.rd = 1'b1;
        tick();
        h0.rd = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("mrst_rdy", 32'(h0.rd_rdy), 32'd0);
        chk("mrst_rd_d", h0.rd_d, 32'd0);
        chk("mrst_slv_addr", s0.addr, 32'd0);
        chk("mrst_uctrl", uctrl0, 32'd0);
        chk("mrst_slv_rd", 32'(s0.rd), 32'd0);
        tick();
        reset_n = 1'b1;
        s0.rd_d = 32'h7777_7777; s0.rd_rdy = 1'b1;
        tick();
        s0.rd_rdy = 1'b0;
        chk("mrst_late_rdy", 32'(h0.rd_rdy), 32'd0);
        tick();
        chk("mrst_late_rdy2", 32'(h0.rd_rdy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
